// File: rtl/spi_register_writer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_register_writer
//  Description : SPI (mode 0, MSB first) slave front-end that turns framed
//                serial register writes into one-cycle register-write strobes
//                in the i_Clock domain. A frame carries a register number
//                followed by one or more value bytes. Every byte after the
//                first is written to the previous number + 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_register_writer #(
   parameter int SYNC_STAGES  = 2,
   parameter int NUMBER_WIDTH = 16,
   parameter int VALUE_WIDTH  = 8
) (
   input  logic                    i_Clock,
   input  logic                    i_Reset_n,
   input  logic                    i_SPI_SCLK,
   input  logic                    i_SPI_CS_n,
   input  logic                    i_SPI_MOSI,
   output logic                    o_RegisterWriteEnable,
   output logic [NUMBER_WIDTH-1:0] o_RegisterWriteNumber,
   output logic [VALUE_WIDTH-1:0]  o_RegisterWriteValue,
   output logic                    o_FrameError,
   output logic                    o_Busy
);

   // Number and value bits share one shift register sized for the wider
   // field. Only the bits before the newest one are stored, because the
   // newest bit comes straight from the synchroniser.
   localparam int c_MAX_W   = (NUMBER_WIDTH > VALUE_WIDTH) ? NUMBER_WIDTH : VALUE_WIDTH;
   localparam int c_CNT_W   = $clog2(c_MAX_W + 1);
   localparam int c_PRIME_W = $clog2(SYNC_STAGES + 2);

   localparam logic [c_CNT_W-1:0]   c_NUM_LAST = c_CNT_W'(NUMBER_WIDTH - 1);
   localparam logic [c_CNT_W-1:0]   c_VAL_LAST = c_CNT_W'(VALUE_WIDTH - 1);
   localparam logic [c_PRIME_W-1:0] c_PRIME    = c_PRIME_W'(SYNC_STAGES + 1);

   typedef enum logic [2:0] {
      S_WAIT_DESELECT = 3'd0,
      S_IDLE          = 3'd1,
      S_NUMBER        = 3'd2,
      S_VALUE         = 3'd3,
      S_COMMIT        = 3'd4
   } state_t;

   // Synchroniser chains and edge-detect flops
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_prev;
   logic                   r_cs_prev;

   // Counts cycles after reset until the chains hold real pin samples
   logic [c_PRIME_W-1:0]   r_prime_cnt;

   // FSM and datapath state
   state_t                 r_state;
   state_t                 w_state_next;
   logic [c_CNT_W-1:0]     r_bit_cnt;
   logic [c_CNT_W-1:0]     w_bit_cnt_next;
   logic [c_MAX_W-2:0]     r_shift;
   logic [c_MAX_W-2:0]     w_shift_next;
   logic [NUMBER_WIDTH-1:0] r_number;
   logic [NUMBER_WIDTH-1:0] w_number_next;
   logic [NUMBER_WIDTH-1:0] r_out_number;
   logic [NUMBER_WIDTH-1:0] w_out_number_next;
   logic [VALUE_WIDTH-1:0]  r_out_value;
   logic [VALUE_WIDTH-1:0]  w_out_value_next;
   logic                   r_frame_error;
   logic                   w_frame_error_next;

   // Synchronised pin levels and derived events
   logic                   w_sclk_s;
   logic                   w_cs_s;
   logic                   w_mosi_s;
   logic                   w_sclk_rise;
   logic                   w_cs_fall;
   logic                   w_primed;
   logic [c_MAX_W-1:0]     w_word;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
   assign w_cs_fall   = ~w_cs_s & r_cs_prev;
   assign w_primed    = (r_prime_cnt == c_PRIME);

   // Received bits so far including the one being sampled this cycle
   assign w_word      = {r_shift, w_mosi_s};

   // Bring the asynchronous SPI pins into the clock domain and keep one
   // extra flop on SCLK and CS_n for edge detection
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_SPI_SCLK};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   i_SPI_CS_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
         r_sclk_prev <= w_sclk_s;
         r_cs_prev   <= w_cs_s;
      end
   end

   // The chains come out of reset showing CS_n high whatever the pin does.
   // Leaving WAIT_DESELECT on that reset value would let a frame that was
   // already running look like a fresh CS_n fall, so wait until the chains
   // have been refilled from the pins before trusting the CS_n level.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_prime_cnt <= '0;
      end else if (!w_primed) begin
         r_prime_cnt <= r_prime_cnt + c_PRIME_W'(1);
      end
   end

   // FSM state register
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_state <= S_WAIT_DESELECT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath registers: bit counter, shift register, number and outputs
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_number      <= '0;
         r_out_number  <= '0;
         r_out_value   <= '0;
         r_frame_error <= 1'b0;
      end else begin
         r_bit_cnt     <= w_bit_cnt_next;
         r_shift       <= w_shift_next;
         r_number      <= w_number_next;
         r_out_number  <= w_out_number_next;
         r_out_value   <= w_out_value_next;
         r_frame_error <= w_frame_error_next;
      end
   end

   // Next-state and datapath decisions. A deselect is checked before any
   // SCLK edge so that a bit arriving together with CS_n rising is dropped.
   // The deselect is tested as a level so that one rising during COMMIT is
   // still seen by VALUE on the following cycle.
   always_comb begin
      w_state_next       = r_state;
      w_bit_cnt_next     = r_bit_cnt;
      w_shift_next       = r_shift;
      w_number_next      = r_number;
      w_out_number_next  = r_out_number;
      w_out_value_next   = r_out_value;
      w_frame_error_next = 1'b0;

      case (r_state)
         S_WAIT_DESELECT: begin
            if (w_primed && w_cs_s) begin
               w_state_next = S_IDLE;
            end
         end

         S_IDLE: begin
            if (w_cs_fall) begin
               w_state_next   = S_NUMBER;
               w_bit_cnt_next = '0;
               w_shift_next   = '0;
            end
         end

         S_NUMBER: begin
            if (w_cs_s) begin
               // Deselected before the number was complete
               w_state_next       = S_IDLE;
               w_frame_error_next = 1'b1;
            end else if (w_sclk_rise) begin
               w_shift_next = w_word[c_MAX_W-2:0];
               if (r_bit_cnt == c_NUM_LAST) begin
                  w_number_next  = w_word[NUMBER_WIDTH-1:0];
                  w_bit_cnt_next = '0;
                  w_state_next   = S_VALUE;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + c_CNT_W'(1);
               end
            end
         end

         S_VALUE: begin
            if (w_cs_s) begin
               // A deselect on a byte boundary is the normal end of a frame
               w_state_next       = S_IDLE;
               w_frame_error_next = (r_bit_cnt != '0);
            end else if (w_sclk_rise) begin
               w_shift_next = w_word[c_MAX_W-2:0];
               if (r_bit_cnt == c_VAL_LAST) begin
                  w_out_number_next = r_number;
                  w_out_value_next  = w_word[VALUE_WIDTH-1:0];
                  w_bit_cnt_next    = '0;
                  w_state_next      = S_COMMIT;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + c_CNT_W'(1);
               end
            end
         end

         S_COMMIT: begin
            // Step to the next register for a possible burst byte; the
            // increment wraps naturally at the field width
            w_number_next = r_number + NUMBER_WIDTH'(1);
            w_state_next  = S_VALUE;
         end

         default: begin
            w_state_next = S_WAIT_DESELECT;
         end
      endcase
   end

   assign o_RegisterWriteEnable = (r_state == S_COMMIT);
   assign o_RegisterWriteNumber = r_out_number;
   assign o_RegisterWriteValue  = r_out_value;
   assign o_FrameError          = r_frame_error;
   assign o_Busy                = (r_state == S_NUMBER) ||
                                  (r_state == S_VALUE)  ||
                                  (r_state == S_COMMIT);

endmodule
`default_nettype wire

// File: tb/tb_spi_register_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_register_writer
//  Description : Self-checking bench for spi_register_writer. Drives SPI
//                frames at i_Clock/4, records expected writes in a
//                scoreboard and checks the observed strobes against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_register_writer;

   localparam int SYNC = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk  = 1'b0;
   logic        cs_n  = 1'b1;
   logic        mosi  = 1'b0;
   logic        we;
   logic [15:0] num;
   logic [7:0]  val;
   logic        ferr;
   logic        busy;

   spi_register_writer #(
      .SYNC_STAGES  (SYNC),
      .NUMBER_WIDTH (16),
      .VALUE_WIDTH  (8)
   ) dut (
      .i_Clock               (clk),
      .i_Reset_n             (rst_n),
      .i_SPI_SCLK            (sclk),
      .i_SPI_CS_n            (cs_n),
      .i_SPI_MOSI            (mosi),
      .o_RegisterWriteEnable (we),
      .o_RegisterWriteNumber (num),
      .o_RegisterWriteValue  (val),
      .o_FrameError          (ferr),
      .o_Busy                (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] num;
      logic [7:0]  val;
      int          cyc;
   } ev_t;

   ev_t sb[$];   // expected writes, pushed by the driver
   ev_t obs[$];  // observed writes, pushed by the monitor
   int  sb_rd  = 0;
   int  obs_rd = 0;
   int  total  = 0;
   int  bad    = 0;
   int  cyc    = 0;
   int  err_cnt = 0;
   int  last_rise = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record strobes and error pulses away from the active edge
   always @(negedge clk) begin
      if (ferr === 1'b1) err_cnt <= err_cnt + 1;
      if (we === 1'b1) obs.push_back('{num: num, val: val, cyc: cyc});
   end

   // ---------------------------------------------------------------- drivers
   task automatic cs_low();
      @(posedge clk); #1;
      cs_n = 1'b0;
      repeat (4) @(posedge clk); #1;
   endtask

   task automatic cs_high();
      sclk = 1'b0;
      repeat (2) @(posedge clk); #1;
      cs_n = 1'b1;
      repeat (8) @(posedge clk); #1;
   endtask

   // One SPI bit at SCLK = clk/4: MOSI set at SCLK fall, held 2 clocks each side
   task automatic send_bit(input logic b);
      mosi = b;
      sclk = 1'b0;
      repeat (2) @(posedge clk); #1;
      sclk = 1'b1;
      last_rise = cyc;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic send_bits(input logic [15:0] d, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
   endtask

   // Full frame: number then n value bytes (MSB byte of vals first)
   task automatic send_frame(input logic [15:0] number, input logic [23:0] vals, input int n);
      logic [7:0]  b;
      logic [15:0] n_exp;
      cs_low();
      send_bits(number, 16);
      for (int k = 0; k < n; k++) begin
         b = vals[23 - 8*k -: 8];
         send_bits({8'h00, b}, 8);
         n_exp = number + 16'(k);
         // strobe follows the final rise by SYNC flops plus one cycle
         sb.push_back('{num: n_exp, val: b, cyc: last_rise + SYNC + 1});
      end
      cs_high();
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk); #1;
      total++;
      if ({we, num, val, ferr, busy} !== 27'd0) begin
         bad++;
         $display("FAIL reset_outputs: got we=%b num=%h val=%h ferr=%b busy=%b, required all 0", we, num, val, ferr, busy);
      end
      rst_n = 1'b1;
      repeat (10) @(posedge clk); #1;
      total++;
      if ({we, ferr, busy} !== 3'b000 || err_cnt != 0 || obs.size() != 0) begin
         bad++;
         $display("FAIL reset_release: got we=%b ferr=%b busy=%b errs=%0d strobes=%0d, required idle", we, ferr, busy, err_cnt, obs.size());
      end
   endtask

   task automatic test_single_write();
      int e0;
      e0 = err_cnt;
      cs_low();
      send_bits(16'hC005, 16);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL single_busy: got busy=%b, required 1", busy);
      end
      send_bits(16'h003A, 8);
      sb.push_back('{num: 16'hC005, val: 8'h3A, cyc: last_rise + SYNC + 1});
      cs_high();
      while (sb_rd < sb.size()) begin
         total++;
         if (obs_rd >= obs.size()) begin
            bad++;
            $display("FAIL single_missing: got no strobe, required num=%h val=%h", sb[sb_rd].num, sb[sb_rd].val);
         end else begin
            if ({obs[obs_rd].num, obs[obs_rd].val} !== {sb[sb_rd].num, sb[sb_rd].val}) begin
               bad++;
               $display("FAIL single_data: got num=%h val=%h, required num=%h val=%h", obs[obs_rd].num, obs[obs_rd].val, sb[sb_rd].num, sb[sb_rd].val);
            end
            obs_rd++;
         end
         sb_rd++;
      end
      total++;
      if (obs_rd != obs.size() || err_cnt != e0) begin
         bad++;
         $display("FAIL single_extra: got strobes=%0d errs=%0d, required strobes=%0d errs=%0d", obs.size(), err_cnt - e0, obs_rd, 0);
      end
      obs_rd = obs.size();
      total++;
      if ({we, num, val, busy} !== {1'b0, 16'hC005, 8'h3A, 1'b0}) begin
         bad++;
         $display("FAIL single_hold: got we=%b num=%h val=%h busy=%b, required 0 C005 3A 0", we, num, val, busy);
      end
   endtask

   task automatic test_burst();
      int s0;
      s0 = obs.size();
      send_frame(16'hC0FF, 24'h112233, 3);
      total++;
      if (obs.size() - s0 != 3) begin
         bad++;
         $display("FAIL burst_count: got %0d strobes, required 3", obs.size() - s0);
      end
      while (sb_rd < sb.size() && obs_rd < obs.size()) begin
         total++;
         if ({obs[obs_rd].num, obs[obs_rd].val} !== {sb[sb_rd].num, sb[sb_rd].val}) begin
            bad++;
            $display("FAIL burst_data: got num=%h val=%h, required num=%h val=%h", obs[obs_rd].num, obs[obs_rd].val, sb[sb_rd].num, sb[sb_rd].val);
         end
         obs_rd++; sb_rd++;
      end
      sb_rd = sb.size(); obs_rd = obs.size();
      total++;
      if ({num, val} !== {16'hC101, 8'h33}) begin
         bad++;
         $display("FAIL burst_last: got num=%h val=%h, required C101 33", num, val);
      end
   endtask

   task automatic test_wrap();
      int s0;
      s0 = obs.size();
      send_frame(16'hFFFF, 24'hAABB00, 2);
      total++;
      if (obs.size() - s0 != 2) begin
         bad++;
         $display("FAIL wrap_count: got %0d strobes, required 2", obs.size() - s0);
      end else begin
         total++;
         if ({obs[s0].num, obs[s0].val, obs[s0+1].num, obs[s0+1].val} !== {16'hFFFF, 8'hAA, 16'h0000, 8'hBB}) begin
            bad++;
            $display("FAIL wrap_data: got %h/%h then %h/%h, required FFFF/AA then 0000/BB", obs[s0].num, obs[s0].val, obs[s0+1].num, obs[s0+1].val);
         end
      end
      sb_rd = sb.size(); obs_rd = obs.size();
   endtask

   task automatic test_abort();
      int s0, e0;
      s0 = obs.size(); e0 = err_cnt;
      cs_low();
      send_bits(16'hC001, 16);
      send_bits(16'h000A, 4);
      cs_high();
      total++;
      if (obs.size() != s0 || err_cnt - e0 != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_error: got strobes=%0d errs=%0d busy=%b, required 0 1 0", obs.size() - s0, err_cnt - e0, busy);
      end
      send_frame(16'h8000, 24'h010000, 1);
      total++;
      if (obs.size() - s0 != 1 || err_cnt - e0 != 1) begin
         bad++;
         $display("FAIL abort_next_count: got strobes=%0d errs=%0d, required 1 1", obs.size() - s0, err_cnt - e0);
      end else begin
         total++;
         if ({obs[s0].num, obs[s0].val} !== {16'h8000, 8'h01}) begin
            bad++;
            $display("FAIL abort_next_data: got num=%h val=%h, required 8000 01", obs[s0].num, obs[s0].val);
         end
      end
      sb_rd = sb.size(); obs_rd = obs.size();
   endtask

   task automatic test_reset_mid_frame();
      int s0, e0;
      s0 = obs.size(); e0 = err_cnt;
      cs_low();
      send_bits(16'h0155, 10);
      rst_n = 1'b0;
      #2;
      total++;
      if ({we, num, val, ferr, busy} !== 27'd0) begin
         bad++;
         $display("FAIL midreset_outputs: got we=%b num=%h val=%h ferr=%b busy=%b, required all 0", we, num, val, ferr, busy);
      end
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      send_bits(16'h2AB3, 14);
      cs_high();
      total++;
      if (obs.size() != s0 || err_cnt != e0) begin
         bad++;
         $display("FAIL midreset_stray: got strobes=%0d errs=%0d, required 0 0", obs.size() - s0, err_cnt - e0);
      end
      send_frame(16'hC002, 24'h550000, 1);
      total++;
      if (obs.size() - s0 != 1 || err_cnt != e0) begin
         bad++;
         $display("FAIL midreset_next_count: got strobes=%0d errs=%0d, required 1 0", obs.size() - s0, err_cnt - e0);
      end else begin
         total++;
         if ({obs[s0].num, obs[s0].val} !== {16'hC002, 8'h55}) begin
            bad++;
            $display("FAIL midreset_next_data: got num=%h val=%h, required C002 55", obs[s0].num, obs[s0].val);
         end
      end
      sb_rd = sb.size(); obs_rd = obs.size();
   endtask

   task automatic test_random_timing();
      int e0;
      e0 = err_cnt;
      for (int f = 0; f < 256; f++) begin
         send_frame(16'($urandom), 24'($urandom), $urandom_range(1, 3));
      end
      while (sb_rd < sb.size()) begin
         total++;
         if (obs_rd >= obs.size()) begin
            bad++;
            $display("FAIL rand_missing: got no strobe, required num=%h val=%h", sb[sb_rd].num, sb[sb_rd].val);
         end else begin
            if ({obs[obs_rd].num, obs[obs_rd].val} !== {sb[sb_rd].num, sb[sb_rd].val}) begin
               bad++;
               $display("FAIL rand_data: got num=%h val=%h, required num=%h val=%h", obs[obs_rd].num, obs[obs_rd].val, sb[sb_rd].num, sb[sb_rd].val);
            end
            total++;
            if (obs[obs_rd].cyc != sb[sb_rd].cyc) begin
               bad++;
               $display("FAIL rand_latency: got strobe cycle %0d, required %0d", obs[obs_rd].cyc, sb[sb_rd].cyc);
            end
            obs_rd++;
         end
         sb_rd++;
      end
      total++;
      if (obs_rd != obs.size() || err_cnt != e0) begin
         bad++;
         $display("FAIL rand_extra: got strobes=%0d errs=%0d, required strobes=%0d errs=0", obs.size(), err_cnt - e0, obs_rd);
      end
      obs_rd = obs.size();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst();
      test_wrap();
      test_abort();
      test_reset_mid_frame();
      test_random_timing();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
